// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Two-port write arbiter in front of a single register-file write port.
// Port 0 (ALU writeback) and port 1 (load writeback) request writes. A
// round-robin grant picks between them when both ask at once. A granted
// write is held on write_en/write_addr/write_data until the register file
// returns reg_ack. The granted port then gets a one-cycle ack. A write to
// register 0 is discarded, because r0 is hardwired zero. It still acks,
// but the register file never sees it.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req0/addr0/data0    write request from port 0
//   ack0                one-cycle completion pulse to port 0
//   req1/addr1/data1    write request from port 1
//   ack1                one-cycle completion pulse to port 1
//   write_en            register-file write strobe
//   write_addr          register-file write address
//   write_data          register-file write data
//   reg_ack             register file has committed the write
//   busy                high whenever the arbiter is not idle
//   write_count         number of committed register-file writes (wraps)
module rf_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0,
  input  logic [$clog2(NUM_REGS)-1:0] addr0,
  input  logic [DATA_W-1:0]           data0,
  output logic                        ack0,
  input  logic                        req1,
  input  logic [$clog2(NUM_REGS)-1:0] addr1,
  input  logic [DATA_W-1:0]           data1,
  output logic                        ack1,
  output logic                        write_en,
  output logic [$clog2(NUM_REGS)-1:0] write_addr,
  output logic [DATA_W-1:0]           write_data,
  input  logic                        reg_ack,
  output logic                        busy,
  output logic [15:0]                 write_count
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic              last_grant;
  logic              held_port;
  logic              mask_valid;
  logic              eff_req0;
  logic              eff_req1;
  logic              grant_valid;
  logic              grant_sel;
  logic              commit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant logic.
  // For the single IDLE cycle after DONE, the port that was just acked is
  // masked. Its requester may still be dropping req, and a stale req must
  // not be granted a second time.
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    commit      = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    eff_req0    = req0 && !(mask_valid && !held_port);
    eff_req1    = req1 && !(mask_valid && held_port);

    case (state)
      IDLE: begin
        if (eff_req0 && eff_req1) begin
          grant_valid = 1'b1;
          grant_sel   = ~last_grant;
        end else if (eff_req0) begin
          grant_valid = 1'b1;
          grant_sel   = 1'b0;
        end else if (eff_req1) begin
          grant_valid = 1'b1;
          grant_sel   = 1'b1;
        end
      end
      WRITE: begin
        if (reg_ack) begin
          commit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        ack0       = ~held_port;
        ack1       = held_port;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    sel_addr = grant_sel ? addr1 : addr0;
    sel_data = grant_sel ? data1 : data0;

    if (grant_valid) begin
      next_state = (sel_addr != '0) ? WRITE : DONE;
    end
  end

  // Datapath and bookkeeping registers.
  // Nothing touches write_addr/write_data on a grant to r0, so the last real
  // write stays on the bus while write_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
      held_port   <= 1'b0;
      mask_valid  <= 1'b0;
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      write_count <= '0;
    end else begin
      mask_valid <= (state == DONE);
      if (grant_valid) begin
        last_grant <= grant_sel;
        held_port  <= grant_sel;
        if (sel_addr != '0) begin
          write_en   <= 1'b1;
          write_addr <= sel_addr;
          write_data <= sel_data;
        end
      end
      if (commit) begin
        write_en    <= 1'b0;
        write_count <= write_count + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Scoreboard bench for rf_write_arbiter.
// The stimulus side applies round-robin arbitration rules to predict the
// order in which ports are serviced. It pushes one expected transaction per
// request into a queue. A monitor samples on the falling edge, pops an entry
// on every ack pulse and checks the following:
//   - the acked port;
//   - the write that was (or was not) presented;
//   - how long write_en stayed up;
//   - the running write count.
// A responder process plays the register file. It raises reg_ack after a
// programmable stall and drives random noise on reg_ack outside writes.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        ack0, ack1;
  logic        write_en;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        reg_ack;
  logic        busy;
  logic [15:0] write_count;

  rf_write_arbiter #(.NUM_REGS(16), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .addr0      (addr0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .addr1      (addr1),
    .data1      (data1),
    .ack1       (ack1),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .reg_ack    (reg_ack),
    .busy       (busy),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [3:0]  addr;
    logic [15:0] data;
    int          stall;
  } txn_t;

  txn_t        exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          stall_cycles = 0;
  bit          noise_en = 1'b0;
  logic        model_last;
  logic [15:0] exp_count;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Register-file model: ack after stall_cycles cycles of write_en.
  int stall_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      reg_ack   = 1'b0;
      stall_cnt = 0;
    end else if (write_en) begin
      if (stall_cnt >= stall_cycles) begin
        reg_ack = 1'b1;
      end else begin
        reg_ack = 1'b0;
        stall_cnt++;
      end
    end else begin
      stall_cnt = 0;
      reg_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: captures each write and scores it when the matching ack arrives.
  logic        we_prev = 1'b0;
  logic [3:0]  cap_addr;
  logic [15:0] cap_data;
  int          we_cycles = 0;
  bit          wrote = 1'b0;
  always @(negedge clk) begin
    txn_t e;
    if (reset) begin
      we_prev   = 1'b0;
      we_cycles = 0;
      wrote     = 1'b0;
    end else begin
      if (write_en) begin
        if (!we_prev) begin
          cap_addr  = write_addr;
          cap_data  = write_data;
          we_cycles = 0;
          wrote     = 1'b1;
        end else begin
          checkOutput("write_addr_stable", write_addr, cap_addr);
          checkOutput("write_data_stable", write_data, cap_data);
        end
        we_cycles++;
        checkOutput("busy_during_write", busy, 1);
      end
      we_prev = write_en;
      if (ack0 || ack1) begin
        checkOutput("ack_exclusive", ack0 & ack1, 0);
        checkOutput("write_en_low_at_ack", write_en, 0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none",
                   ack0, ack1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_port", {ack1, ack0}, e.port ? 2'b10 : 2'b01);
          if (e.addr != 4'd0) begin
            exp_count = exp_count + 16'd1;
            checkOutput("write_seen", wrote, 1);
            checkOutput("write_addr", cap_addr, e.addr);
            checkOutput("write_data", cap_data, e.data);
            checkOutput("write_en_cycles", we_cycles, e.stall + 1);
          end else begin
            checkOutput("r0_no_write", wrote, 0);
          end
          checkOutput("write_count", write_count, exp_count);
        end
        wrote = 1'b0;
      end
    end
  end

  // Issue one request (or a simultaneous pair), predict the service order
  // and behave as the requesters: each port drops req one cycle after its ack.
  task automatic applyStimulus(input logic r0, input logic [3:0] a0,
                               input logic [15:0] d0, input logic r1,
                               input logic [3:0] a1, input logic [15:0] d1,
                               input int stall);
    logic first;
    bit   pend0, pend1, drop0, drop1;
    int   cycles;
    @(negedge clk);
    stall_cycles = stall;
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    if (r0 && r1) begin
      first = ~model_last;
      exp_q.push_back(first ? txn_t'{1'b1, a1, d1, stall} : txn_t'{1'b0, a0, d0, stall});
      exp_q.push_back(first ? txn_t'{1'b0, a0, d0, stall} : txn_t'{1'b1, a1, d1, stall});
      model_last = ~first;
    end else if (r0) begin
      exp_q.push_back(txn_t'{1'b0, a0, d0, stall});
      model_last = 1'b0;
    end else if (r1) begin
      exp_q.push_back(txn_t'{1'b1, a1, d1, stall});
      model_last = 1'b1;
    end
    pend0 = r0; pend1 = r1; drop0 = 0; drop1 = 0; cycles = 0;
    while ((pend0 || pend1 || drop0 || drop1) && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (drop0) begin req0 = 1'b0; drop0 = 0; end
      if (drop1) begin req1 = 1'b0; drop1 = 0; end
      if (pend0 && ack0) begin pend0 = 0; drop0 = 1; end
      if (pend1 && ack1) begin pend1 = 0; drop1 = 1; end
    end
    if (pend0 || pend1 || drop0 || drop1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ack_timeout: pending port0=%0b port1=%0b after %0d cycles, expected acks",
               pend0, pend1, cycles);
      req0 = 1'b0;
      req1 = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    model_last = 1'b1;
    exp_count  = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack0", ack0, 0);
    checkOutput("reset_ack1", ack1, 0);
    checkOutput("reset_write_en", write_en, 0);
    checkOutput("reset_write_addr", write_addr, 0);
    checkOutput("reset_write_data", write_data, 0);
    checkOutput("reset_write_count", write_count, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single write");
    applyStimulus(1, 4'd5, 16'hBEEF, 0, 4'd0, 16'h0, 0);
    $display("[TB] simultaneous requests, twice");
    applyStimulus(1, 4'd3, 16'h3333, 1, 4'd7, 16'h7777, 0);
    applyStimulus(1, 4'd3, 16'h3131, 1, 4'd7, 16'h7171, 1);
    $display("[TB] r0 discard");
    applyStimulus(0, 4'd0, 16'h0, 1, 4'd0, 16'h1234, 0);
    $display("[TB] stalled register file");
    applyStimulus(1, 4'd4, 16'hA5A5, 0, 4'd0, 16'h0, 10);

    $display("[TB] reset mid-write");
    @(negedge clk);
    stall_cycles = 20;
    req0 = 1'b1; addr0 = 4'd9; data0 = 16'h1357;
    for (int i = 0; i < 10 && !write_en; i++) @(negedge clk);
    checkOutput("midwrite_write_en_up", write_en, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_write_en", write_en, 0);
    checkOutput("midreset_ack0", ack0, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_write_addr", write_addr, 0);
    checkOutput("midreset_write_data", write_data, 0);
    checkOutput("midreset_write_count", write_count, 0);
    req0 = 1'b0;
    exp_q.delete();
    model_last = 1'b1;
    exp_count  = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_idle", busy, 0);
    applyStimulus(1, 4'd9, 16'h1357, 0, 4'd0, 16'h0, 0);

    $display("[TB] randomized traffic");
    noise_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      logic [3:0] ra0, ra1;
      r   = 2'($urandom_range(1, 3));
      ra0 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ra1 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus(r[0], ra0, 16'($urandom), r[1], ra1, 16'($urandom),
                    $urandom_range(0, 4));
    end
    noise_en = 1'b0;

    $display("[TB] counter wrap");
    @(negedge clk);
    force dut.write_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.write_count;
    exp_count = 16'hFFFE;
    applyStimulus(1, 4'd1, 16'h0101, 0, 4'd0, 16'h0, 0);
    applyStimulus(0, 4'd0, 16'h0, 1, 4'd2, 16'h0202, 0);
    checkOutput("wrap_count", write_count, 16'h0000);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
